// File: rtl/fsm_seq_counter_pkg.sv
// Shared types and constants for the sequence-table counter.
// Holds the FSM state enum, the dice default sequence, the default-table
// helper, and the LFSR seed/tap mask. The LFSR constants are used only
// when FSM_SEQ_COUNTER_ROLL_EN is defined.
package fsm_seq_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Dice sequence {1,6,3,5,4,2}, with entry i stored in bits [3*i +: 3].
    localparam int          DICE_DEPTH = 6;
    localparam logic [17:0] DICE_SEQ   = {3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd1};

    // 8-bit Fibonacci LFSR with taps 8,6,5,4, which are bits 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Reset contents of table entry i. The dice sequence is used when it
    // fits the table shape. Otherwise the entry is i mod 2^width.
    function automatic int default_entry(input int depth, input int width, input int i);
        int value;
        if (depth == DICE_DEPTH && width >= 3 && i >= 0 && i < DICE_DEPTH) begin
            value = int'(DICE_SEQ[i*3 +: 3]);
        end else if (width >= 31) begin
            value = i;
        end else begin
            value = i % (1 << width);
        end
        return value;
    endfunction

endpackage

// File: rtl/fsm_seq_counter_lfsr.sv
// seq_lfsr8: free-running 8-bit Fibonacci LFSR that picks the roll position.
// The whole file is only compiled when FSM_SEQ_COUNTER_ROLL_EN is defined,
// so the default build carries no LFSR.
`ifdef FSM_SEQ_COUNTER_ROLL_EN
module seq_lfsr8
    import fsm_seq_counter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_reg;

    // Shift left by one bit every cycle. The new LSB is the XOR of the tapped bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
        end
    end

    assign lfsr = lfsr_reg;

endmodule
`endif

// File: rtl/fsm_seq_counter.sv
// fsm_seq_counter: walks a writable value table forwards or backwards.
// It has a two-state IDLE/RUN FSM, jump support, and a one-cycle wrap pulse.
// Optional feature: define FSM_SEQ_COUNTER_ROLL_EN to add a 'roll' input.
// A roll moves idx to a pseudo-random position taken from seq_lfsr8.
module fsm_seq_counter
    import fsm_seq_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       dir,
    input  logic [$clog2(DEPTH+1)-1:0] len,
    input  logic                       jump,
    input  logic [$clog2(DEPTH)-1:0]   jump_idx,
`ifdef FSM_SEQ_COUNTER_ROLL_EN
    input  logic                       roll,
`endif
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           num,
    output logic [$clog2(DEPTH)-1:0]   idx,
    output logic                       wrap,
    output logic                       running
);

    localparam int              IW      = $clog2(DEPTH);
    localparam int              LW      = $clog2(DEPTH + 1);
    localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0]   ONE_L   = LW'(1);
    localparam logic [IW-1:0]   ONE_I   = IW'(1);

    state_t           state_reg, state_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             wrap_reg, wrap_next;
    logic [WIDTH-1:0] num_reg;
    logic [WIDTH-1:0] mem_reg  [DEPTH];
    logic [WIDTH-1:0] init_tbl [DEPTH];

    logic [LW-1:0]    len_eff;
    logic [IW-1:0]    last_idx;
    logic [IW-1:0]    jump_tgt;
    logic [IW-1:0]    fwd_idx, bwd_idx;
    logic             fwd_wrap, bwd_wrap;
    logic             roll_req;
    logic [IW-1:0]    roll_idx;

    // Reset image of the table, one constant per entry.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_init
            assign init_tbl[gi] = WIDTH'(default_entry(DEPTH, WIDTH, gi));
        end
    endgenerate

`ifdef FSM_SEQ_COUNTER_ROLL_EN
    logic [7:0] lfsr_val;
    logic [7:0] roll_mod;

    seq_lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .lfsr  (lfsr_val)
    );

    // The roll target is the LFSR value reduced into the active sequence length.
    always_comb begin
        roll_mod = lfsr_val % 8'(len_eff);
        roll_idx = IW'(roll_mod);
        roll_req = roll;
    end
`else
    assign roll_req = 1'b0;
    assign roll_idx = '0;
`endif

    // Effective length: 0 or anything above DEPTH means the full table.
    always_comb begin
        len_eff  = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
        last_idx = IW'(len_eff - ONE_L);
        jump_tgt = (LW'(jump_idx) >= len_eff) ? last_idx : jump_idx;
    end

    // Candidate positions for a step in each direction.
    // An idx left beyond a shrunken len is pulled back in range.
    always_comb begin
        fwd_wrap = (idx_reg >= last_idx);
        fwd_idx  = fwd_wrap ? '0 : idx_reg + ONE_I;
        bwd_wrap = (idx_reg == '0);
        if (bwd_wrap || idx_reg > last_idx) begin
            bwd_idx = last_idx;
        end else begin
            bwd_idx = idx_reg - ONE_I;
        end
    end

    // Next-state logic. Priority is jump > roll > en.
    // Only an en step can raise wrap.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        wrap_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (jump) begin
                    state_next = RUN;
                    idx_next   = jump_tgt;
                end else if (roll_req) begin
                    state_next = RUN;
                    idx_next   = roll_idx;
                end else if (en) begin
                    state_next = RUN;
                    idx_next   = '0;
                end
            end
            RUN: begin
                if (jump) begin
                    idx_next = jump_tgt;
                end else if (roll_req) begin
                    idx_next = roll_idx;
                end else if (en) begin
                    idx_next  = dir ? bwd_idx : fwd_idx;
                    wrap_next = dir ? bwd_wrap : fwd_wrap;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // FSM and output registers. num reads the table before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            wrap_reg  <= 1'b0;
            num_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            wrap_reg  <= wrap_next;
            num_reg   <= (state_next == RUN) ? mem_reg[idx_next] : '0;
        end
    end

    // Value table. Reset reloads the defaults and overrides any write.
    // Out-of-range write addresses are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= init_tbl[i];
            end
        end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    assign num     = num_reg;
    assign idx     = idx_reg;
    assign wrap    = wrap_reg;
    assign running = (state_reg == RUN);

endmodule

// File: tb/tb_fsm_seq_counter.sv
// Scoreboard bench for fsm_seq_counter.
// The driver applies one input set per cycle and pushes the model's expected
// post-edge outputs into a queue. The monitor pops and compares after each edge.
module tb_fsm_seq_counter;

    localparam int WIDTH = 3;
    localparam int DEPTH = 6;
    localparam int IW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int DICE [6] = '{1, 6, 3, 5, 4, 2};

    logic             clk = 1'b0;
    logic             reset, en, dir, jump, wr_en;
    logic [LW-1:0]    len;
    logic [IW-1:0]    jump_idx, wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] num;
    logic [IW-1:0]    idx;
    logic             wrap, running;
`ifdef FSM_SEQ_COUNTER_ROLL_EN
    logic             roll;
`endif

    always #5 clk = ~clk;

    fsm_seq_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .len      (len),
        .jump     (jump),
        .jump_idx (jump_idx),
`ifdef FSM_SEQ_COUNTER_ROLL_EN
        .roll     (roll),
`endif
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .num      (num),
        .idx      (idx),
        .wrap     (wrap),
        .running  (running)
    );

    typedef struct {
        int num;
        int idx;
        int wrap;
        int running;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    // Reference model state: table contents, running flag, position, LFSR value.
    int tbl [DEPTH];
    int run_m = 0;
    int pos_m = 0;
    int lfsr_m = 'hA5;

    function automatic int lfsr_adv(input int v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return ((v << 1) & 255) | fb;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s (txn %0d): got %0d expected %0d", name, txn, act, exp);
        end
    endfunction

    // Apply one cycle of inputs and queue the expected outputs after the next edge.
    task automatic drive(input int r, input int e, input int d, input int l, input int j,
                         input int ji, input int we, input int wa, input int wd, input int ro);
        exp_t x;
        int   eff_len, npos, nrun, nwrap;
        @(negedge clk);
        reset    = r[0];
        en       = e[0];
        dir      = d[0];
        len      = LW'(l);
        jump     = j[0];
        jump_idx = IW'(ji);
        wr_en    = we[0];
        wr_addr  = IW'(wa);
        wr_data  = WIDTH'(wd);
`ifdef FSM_SEQ_COUNTER_ROLL_EN
        roll     = ro[0];
`endif
        if (r != 0) begin
            for (int i = 0; i < DEPTH; i++) tbl[i] = DICE[i];
            run_m = 0;
            pos_m = 0;
            x = '{num: 0, idx: 0, wrap: 0, running: 0};
        end else begin
            eff_len = (l == 0 || l > DEPTH) ? DEPTH : l;
            nrun  = run_m;
            npos  = pos_m;
            nwrap = 0;
            if (j != 0) begin
                nrun = 1;
                npos = (ji >= eff_len) ? eff_len - 1 : ji;
            end else if (ro != 0) begin
                nrun = 1;
                npos = lfsr_m % eff_len;
            end else if (e != 0) begin
                if (run_m == 0) begin
                    nrun = 1;
                    npos = 0;
                end else if (d == 0) begin
                    if (pos_m >= eff_len - 1) begin
                        npos = 0;
                        nwrap = 1;
                    end else begin
                        npos = pos_m + 1;
                    end
                end else begin
                    if (pos_m == 0) begin
                        npos = eff_len - 1;
                        nwrap = 1;
                    end else if (pos_m > eff_len - 1) begin
                        npos = eff_len - 1;
                    end else begin
                        npos = pos_m - 1;
                    end
                end
            end
            x.num     = (nrun != 0) ? tbl[npos] : 0;
            x.idx     = npos;
            x.wrap    = nwrap;
            x.running = nrun;
            if (we != 0 && wa < DEPTH) tbl[wa] = wd;
            run_m = nrun;
            pos_m = npos;
        end
        lfsr_m = (r != 0) ? 'hA5 : lfsr_adv(lfsr_m);
        exp_q.push_back(x);
    endtask

    task automatic en_cycles(input int n, input int d, input int l);
        for (int k = 0; k < n; k++) drive(0, 1, d, l, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare the DUT outputs against the queued expectation after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: num=%0d idx=%0d wrap=%0d running=%0d (exp %0d/%0d/%0d/%0d)",
                         txn, num, idx, wrap, running, e.num, e.idx, e.wrap, e.running);
                check("num", 32'(num), e.num);
                check("idx", 32'(idx), e.idx);
                check("wrap", 32'(wrap), e.wrap);
                check("running", 32'(running), e.running);
            end
        end
    end

    initial begin
        int ro;
        reset = 1'b1; en = 1'b0; dir = 1'b0; len = '0; jump = 1'b0;
        jump_idx = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`ifdef FSM_SEQ_COUNTER_ROLL_EN
        roll = 1'b0;
`endif
        // Forward walk through the dice table, including the wrap back to the first entry.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        en_cycles(7, 0, 0);
        // Backward walk from IDLE.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        en_cycles(7, 1, 0);
        // Shrink len while idx is outside the new range, then step backward from 0.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        en_cycles(5, 0, 0);
        en_cycles(1, 0, 3);
        en_cycles(1, 1, 3);
        // len=1 keeps idx at 0 and pulses wrap on every step.
        en_cycles(3, 0, 1);
        en_cycles(2, 1, 1);
        // A write and a step on the same edge: old value first, new value on the next cycle.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        en_cycles(2, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 2, 7, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 7, 5, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // A jump past len is clamped, and jump takes priority over en.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 4, 1, 5, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 1, 7, 0, 0, 0, 0);
        // A reset together with a write abandons the run and restores the table.
        en_cycles(3, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 1, 0, 7, 0);
        en_cycles(7, 0, 0);
`ifdef FSM_SEQ_COUNTER_ROLL_EN
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
`endif
        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            ro = 0;
`ifdef FSM_SEQ_COUNTER_ROLL_EN
            ro = ($urandom_range(0, 9) == 0) ? 1 : 0;
`endif
            drive(($urandom_range(0, 49) == 0) ? 1 : 0,
                  ($urandom_range(0, 9) < 6) ? 1 : 0,
                  int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0) ? 1 : 0,
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 4) == 0) ? 1 : 0,
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)),
                  ro);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Let the monitor drain the queue, with a bounded wait.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
